// File: rtl/apb_slave_mux.sv
// APB bridge that decodes one upstream request onto one of NSLV downstream slaves.
// Unmapped addresses and slaves that stall past TIMEOUT are answered with an error response.
module apb_slave_mux #(
    parameter int NSLV       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NSLV*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NSLV*ADDR_WIDTH-1:0] SLV_MASK = {4{32'hFFFF_F000}},
    parameter int TIMEOUT    = 255
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       req_psel_i,
    input  logic                       req_penable_i,
    input  logic                       req_pwrite_i,
    input  logic [ADDR_WIDTH-1:0]      req_paddr_i,
    input  logic [DATA_WIDTH-1:0]      req_pwdata_i,
    output logic [DATA_WIDTH-1:0]      req_prdata_o,
    output logic                       req_pready_o,
    output logic                       req_pslverr_o,
    output logic [NSLV-1:0]            PSEL_o,
    output logic                       PENABLE_o,
    output logic                       PWRITE_o,
    output logic [ADDR_WIDTH-1:0]      PADDR_o,
    output logic [DATA_WIDTH-1:0]      PWDATA_o,
    input  logic [NSLV*DATA_WIDTH-1:0] PRDATA_i,
    input  logic [NSLV-1:0]            PREADY_i,
    input  logic [NSLV-1:0]            PSLVERR_i,
    output logic [7:0]                 err_cnt_o
);

    localparam int         IDX_W     = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state, state_next;
    logic [IDX_W-1:0]       sel_idx, hit_idx;
    logic                   hit;
    logic [7:0]             wait_cnt;
    logic                   resp_err;

    logic                   latch_req, cap, cap_err, cnt_clr, cnt_inc;
    logic [DATA_WIDTH-1:0]  cap_data;
    logic                   sel_ready, sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;

    // The upstream select carries no information beyond req_penable_i here.
    logic unused_psel;
    assign unused_psel = req_psel_i;

    // Scan from the top down so the lowest matching slave index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if ((req_paddr_i & SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLV_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    assign sel_ready = PREADY_i[sel_idx];
    assign sel_err   = PSLVERR_i[sel_idx];
    assign sel_rdata = PRDATA_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_next = state;
        latch_req  = 1'b0;
        cap        = 1'b0;
        cap_err    = 1'b0;
        cap_data   = '0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (req_penable_i) begin
                    latch_req = 1'b1;
                    if (hit) begin
                        state_next = SETUP;
                    end else begin
                        state_next = RESP;
                        cap        = 1'b1;
                        cap_err    = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_clr    = 1'b1;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_next = RESP;
                    cap        = 1'b1;
                    cap_err    = sel_err;
                    cap_data   = PWRITE_o ? '0 : sel_rdata;
                end else begin
                    cnt_inc = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = RESP;
                        cap        = 1'b1;
                        cap_err    = 1'b1;
                    end
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state        <= IDLE;
            sel_idx      <= '0;
            PWRITE_o     <= 1'b0;
            PADDR_o      <= '0;
            PWDATA_o     <= '0;
            wait_cnt     <= '0;
            req_prdata_o <= '0;
            resp_err     <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            state <= state_next;
            if (latch_req) begin
                sel_idx  <= hit_idx;
                PWRITE_o <= req_pwrite_i;
                PADDR_o  <= req_paddr_i;
                PWDATA_o <= req_pwdata_i;
            end
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (cap) begin
                req_prdata_o <= cap_data;
                resp_err     <= cap_err;
            end
            if (state == RESP && resp_err && err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

    // Downstream strobes come straight from the state so reset removes them at once.
    always_comb begin
        PSEL_o = '0;
        if (state == SETUP || state == ACCESS) begin
            PSEL_o[sel_idx] = 1'b1;
        end
    end

    assign PENABLE_o     = (state == ACCESS);
    assign req_pready_o  = (state == RESP);
    assign req_pslverr_o = (state == RESP) && resp_err;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Directed-vector bench for apb_slave_mux: one table of single transfers plus
// hand-written sequences for error-count saturation and mid-transfer reset.
module tb_apb_slave_mux;

    logic         ACLK;
    logic         ARESETn;
    logic         req_psel_i;
    logic         req_penable_i;
    logic         req_pwrite_i;
    logic [31:0]  req_paddr_i;
    logic [31:0]  req_pwdata_i;
    logic [31:0]  req_prdata_o;
    logic         req_pready_o;
    logic         req_pslverr_o;
    logic [3:0]   PSEL_o;
    logic         PENABLE_o;
    logic         PWRITE_o;
    logic [31:0]  PADDR_o;
    logic [31:0]  PWDATA_o;
    logic [127:0] PRDATA_i;
    logic [3:0]   PREADY_i;
    logic [3:0]   PSLVERR_i;
    logic [7:0]   err_cnt_o;

    int checks   = 0;
    int failures = 0;
    int errModel = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          slv;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
        logic        dropEn;
        logic [3:0]  expPsel;
        int          expCyc;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs[7];

    apb_slave_mux dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .req_psel_i    (req_psel_i),
        .req_penable_i (req_penable_i),
        .req_pwrite_i  (req_pwrite_i),
        .req_paddr_i   (req_paddr_i),
        .req_pwdata_i  (req_pwdata_i),
        .req_prdata_o  (req_prdata_o),
        .req_pready_o  (req_pready_o),
        .req_pslverr_o (req_pslverr_o),
        .PSEL_o        (PSEL_o),
        .PENABLE_o     (PENABLE_o),
        .PWRITE_o      (PWRITE_o),
        .PADDR_o       (PADDR_o),
        .PWDATA_o      (PWDATA_o),
        .PRDATA_i      (PRDATA_i),
        .PREADY_i      (PREADY_i),
        .PSLVERR_i     (PSLVERR_i),
        .err_cnt_o     (err_cnt_o)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transfer cycle by cycle; cycle 0 is the IDLE cycle that sees the request.
    task automatic applyStimulus(input int id, input vec_t v);
        int          readyCyc = -1;
        logic [31:0] gotRdata = '0;
        logic        gotErr   = 1'b0;
        logic        pselBad  = 1'b0;
        logic        penBad   = 1'b0;
        logic        holdBad  = 1'b0;
        logic        errBad   = 1'b0;
        logic [3:0]  expPsel;
        logic        expPen;

        @(negedge ACLK);
        req_penable_i = 1'b1;
        req_psel_i    = 1'b1;
        req_pwrite_i  = v.write;
        req_paddr_i   = v.addr;
        req_pwdata_i  = v.wdata;
        for (int k = 0; k < 4; k++) begin
            PRDATA_i[k*32 +: 32] = (k == v.slv) ? v.rdata : (32'h7770_0000 + 32'(k));
        end
        PSLVERR_i = v.slverr ? 4'(1 << v.slv) : 4'b0;

        for (int cyc = 0; cyc < 300; cyc++) begin
            expPsel = (cyc >= 1 && cyc < v.expCyc) ? v.expPsel : 4'b0;
            expPen  = (v.expPsel != 4'b0) && cyc >= 2 && cyc < v.expCyc;
            if (PSEL_o !== expPsel) pselBad = 1'b1;
            if (PENABLE_o !== expPen) penBad = 1'b1;
            if (cyc >= 1 && cyc < v.expCyc &&
                (PADDR_o !== v.addr || PWDATA_o !== v.wdata || PWRITE_o !== v.write)) holdBad = 1'b1;
            if (!req_pready_o && req_pslverr_o) errBad = 1'b1;
            if (req_pready_o) begin
                readyCyc      = cyc;
                gotRdata      = req_prdata_o;
                gotErr        = req_pslverr_o;
                req_penable_i = 1'b0;
                req_psel_i    = 1'b0;
                PREADY_i      = 4'b0;
                break;
            end
            PREADY_i = (cyc >= 2 + v.waits) ? 4'(1 << v.slv) : 4'b0;
            if (v.dropEn && cyc == 1) req_penable_i = 1'b0;
            @(posedge ACLK);
            @(negedge ACLK);
        end
        // Step into the following IDLE cycle where the error count has updated.
        @(posedge ACLK);
        @(negedge ACLK);
        if (v.expErr && errModel < 255) errModel++;

        checkOutput($sformatf("vec%0d_ready_cycle", id), 64'(readyCyc), 64'(v.expCyc));
        checkOutput($sformatf("vec%0d_prdata", id), 64'(gotRdata), 64'(v.expRdata));
        checkOutput($sformatf("vec%0d_pslverr", id), 64'(gotErr), 64'(v.expErr));
        checkOutput($sformatf("vec%0d_psel_seq", id), 64'(pselBad), 64'd0);
        checkOutput($sformatf("vec%0d_penable_seq", id), 64'(penBad), 64'd0);
        checkOutput($sformatf("vec%0d_latched_stable", id), 64'(holdBad), 64'd0);
        checkOutput($sformatf("vec%0d_pslverr_outside", id), 64'(errBad), 64'd0);
        checkOutput($sformatf("vec%0d_err_cnt", id), 64'(err_cnt_o), 64'(errModel));
        checkOutput($sformatf("vec%0d_prdata_hold", id), 64'(req_prdata_o), 64'(v.expRdata));
        checkOutput($sformatf("vec%0d_pready_single", id), 64'(req_pready_o), 64'd0);
    endtask

    initial begin
        ARESETn       = 1'b0;
        req_psel_i    = 1'b0;
        req_penable_i = 1'b0;
        req_pwrite_i  = 1'b0;
        req_paddr_i   = '0;
        req_pwdata_i  = '0;
        PRDATA_i      = '0;
        PREADY_i      = '0;
        PSLVERR_i     = '0;

        //          wr    addr          wdata         slv waits err  rdata         drop psel     cyc  exp rdata     exp err
        vecs[0] = '{1'b0, 32'h0000_1004, 32'h0,        1, 0,    1'b0, 32'hDEAD_BEEF, 1'b0, 4'b0010, 3,   32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_3010, 32'hA5A5_A5A5, 3, 5,   1'b0, 32'h1234_5678, 1'b0, 4'b1000, 8,   32'h0,         1'b0};
        vecs[2] = '{1'b0, 32'h0000_8000, 32'h0,        0, 0,    1'b0, 32'h0000_0055, 1'b0, 4'b0000, 1,   32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h0000_0FFC, 32'h0,        0, 2,    1'b1, 32'h0BAD_F00D, 1'b0, 4'b0001, 5,   32'h0BAD_F00D, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_2000, 32'h0,        2, 0,    1'b0, 32'hCAFE_F00D, 1'b1, 4'b0100, 3,   32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_1FFF, 32'h0F0F_1234, 1, 1,   1'b0, 32'h5555_AAAA, 1'b0, 4'b0010, 4,   32'h0,         1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,        0, 1000, 1'b0, 32'h9999_9999, 1'b0, 4'b0001, 257, 32'h0,         1'b1};

        #12;
        checkOutput("reset_psel", 64'(PSEL_o), 64'd0);
        checkOutput("reset_penable", 64'(PENABLE_o), 64'd0);
        checkOutput("reset_pready", 64'(req_pready_o), 64'd0);
        checkOutput("reset_pslverr", 64'(req_pslverr_o), 64'd0);
        checkOutput("reset_prdata", 64'(req_prdata_o), 64'd0);
        checkOutput("reset_err_cnt", 64'(err_cnt_o), 64'd0);
        checkOutput("reset_paddr", 64'({PWRITE_o, PADDR_o, PWDATA_o}), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Drive the error counter to its ceiling, then add one more slave error.
        while (errModel < 255) begin
            applyStimulus(2, vecs[2]);
        end
        checkOutput("err_cnt_at_max", 64'(err_cnt_o), 64'd255);
        applyStimulus(3, vecs[3]);
        checkOutput("err_cnt_saturated", 64'(err_cnt_o), 64'd255);

        // Reset landing in the middle of an ACCESS phase.
        @(negedge ACLK);
        req_penable_i = 1'b1;
        req_pwrite_i  = 1'b0;
        req_paddr_i   = 32'h0000_2004;
        PREADY_i      = 4'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("midrst_in_access", 64'({PSEL_o, PENABLE_o}), 64'({4'b0100, 1'b1}));
        #2;
        ARESETn = 1'b0;
        #1;
        checkOutput("midrst_psel", 64'(PSEL_o), 64'd0);
        checkOutput("midrst_penable", 64'(PENABLE_o), 64'd0);
        checkOutput("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
        checkOutput("midrst_prdata", 64'(req_prdata_o), 64'd0);
        req_penable_i = 1'b0;
        @(negedge ACLK);
        checkOutput("midrst_no_pready", 64'({req_pready_o, req_pslverr_o}), 64'd0);
        @(negedge ACLK);
        ARESETn  = 1'b1;
        errModel = 0;
        applyStimulus(0, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
